// File: rtl/arbiter_rr_burst_pkg.sv
// Shared memory-side definitions: default bus widths, burst length and the
// arbiter state encoding used by the round-robin SDRAM request arbiter.
package mem_pkg;

   localparam int AN_DEF    = 24;
   localparam int DN_DEF    = 16;
   localparam int BURST_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WBURST
   } arbState_e;

endpackage

// File: rtl/arbiter_rr_burst_if.sv
// Bundles the per-master request bus and the single SDRAM request/return port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface arbiter_rr_burst_if
   import mem_pkg::*;
#(
   parameter int N  = 4,
   parameter int AN = AN_DEF,
   parameter int DN = DN_DEF,
   parameter int IN = $clog2(N)
);

   logic [N-1:0]          req;
   logic [N-1:0]          wr;
   logic [N-1:0][AN-1:0]  addr;
   logic [N-1:0][DN-1:0]  data;
   logic [N-1:0]          ack;
   logic [N-1:0]          valid;

   logic                  mem_req;
   logic                  mem_wr;
   logic [AN-1:0]         mem_addr;
   logic [DN-1:0]         mem_data;
   logic [IN-1:0]         mem_id;
   logic                  mem_ack;
   logic                  mem_valid;
   logic [IN-1:0]         mem_rid;

   modport slave (
      input  req, wr, addr, data, mem_ack, mem_valid, mem_rid,
      output ack, valid, mem_req, mem_wr, mem_addr, mem_data, mem_id
   );

   modport master (
      output req, wr, addr, data, mem_ack, mem_valid, mem_rid,
      input  ack, valid, mem_req, mem_wr, mem_addr, mem_data, mem_id
   );

endinterface

// File: rtl/arbiter_rr_burst_rr_pick.sv
// Rotating priority encoder: returns the first set request at or above the
// pointer, wrapping from N-1 back to 0, plus a flag saying any bit was set.
module rr_pick #(
   parameter int N  = 4,
   parameter int IN = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IN-1:0] ptr_i,
   output logic [IN-1:0] idx_o,
   output logic          any_o
);

   // Scan from the farthest slot back toward the pointer so the closest wins.
   always_comb begin
      int j;
      j     = 0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr_i) + i;
         if (j >= N) begin
            j = j - N;
         end
         if (req_i[IN'(j)]) begin
            idx_o = IN'(j);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbiter_rr_burst.sv
// Round-robin arbiter sharing one SDRAM request port between N masters; write
// grants are locked for a full burst and read returns are steered back by ID.
module arbiter_rr_burst
   import mem_pkg::*;
#(
   parameter int AN    = AN_DEF,
   parameter int DN    = DN_DEF,
   parameter int N     = 4,
   parameter int BURST = BURST_DEF
) (
   input  logic               clkSYS,
   input  logic               reset,
   arbiter_rr_burst_if.slave  bus
);

   localparam int IN = $clog2(N);
   localparam int CW = $clog2(BURST);

   arbState_e     state_q, state_d;
   logic [IN-1:0] gnt_q, gnt_d;
   logic [IN-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IN-1:0] pickIdx;
   logic [IN-1:0] gntNext;
   logic          pickAny;
   logic          memReq;
   logic          memWr;
   logic [N-1:0]  ackVec;
   logic [N-1:0]  validVec;

   rr_pick #(
      .N  (N),
      .IN (IN)
   ) u_pick (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .idx_o (pickIdx),
      .any_o (pickAny)
   );

   // Explicit wrap keeps the pointer legal when N is not a power of two.
   assign gntNext = (gnt_q == IN'(N - 1)) ? '0 : gnt_q + 1'b1;

   always_ff @(posedge clkSYS) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // A dropped req mid-burst only lowers mem_req; the grant stays locked.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      memReq  = 1'b0;
      memWr   = 1'b0;
      ackVec  = '0;
      case (state_q)
         IDLE: begin
            if (pickAny) begin
               gnt_d   = pickIdx;
               cnt_d   = '0;
               state_d = bus.wr[pickIdx] ? WBURST : READ;
            end
         end
         READ: begin
            memReq         = bus.req[gnt_q];
            ackVec[gnt_q]  = bus.mem_ack;
            if (bus.mem_ack) begin
               ptr_d   = gntNext;
               state_d = IDLE;
            end
         end
         WBURST: begin
            memReq         = bus.req[gnt_q];
            memWr          = 1'b1;
            ackVec[gnt_q]  = bus.mem_ack;
            if (bus.mem_ack) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(BURST - 1)) begin
                  ptr_d   = gntNext;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Return path ignores grant state so read data can overlap a new grant.
   always_comb begin
      validVec = '0;
      for (int i = 0; i < N; i++) begin
         validVec[i] = bus.mem_valid && (bus.mem_rid == IN'(i));
      end
   end

   assign bus.mem_req  = memReq;
   assign bus.mem_wr   = memWr;
   assign bus.mem_addr = bus.addr[gnt_q];
   assign bus.mem_data = bus.data[gnt_q];
   assign bus.mem_id   = gnt_q;
   assign bus.ack      = ackVec;
   assign bus.valid    = validVec;

endmodule

// File: doc/arbiter_rr_burst.md
Name: arbiter_rr_burst

Overview:
Round-robin arbiter sharing the single SDRAM controller request port between N masters (TFT fetch, waveform display, future capture/CPU ports). It replaces fixed priority with a starvation-free rotating grant. It locks a write grant for a full BURST of data words and routes returned read data strobes back to the originating master by ID. It sits in the clkSYS domain between the masters and the sdram block.

Parameters:
AN, 24, address width
DN, 16, data width
N, 4, number of requesters (2..8)
IN, $clog2(N), ID width
BURST, 8, words per write burst and per read return

Ports:
clkSYS  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  N  per-master request, held until ack
wr  in  N  per-master write flag, valid with req
addr  in  N x AN  per-master address, valid with req
data  in  N x DN  per-master write data, advances on each ack during a write
ack  out  N  per-master accept strobe, one-hot or zero
mem_req  out  1  request to sdram
mem_wr  out  1  write flag to sdram
mem_addr  out  AN  address to sdram
mem_data  out  DN  write data to sdram
mem_id  out  IN  requester ID tagged on request
mem_ack  in  1  sdram accepted current word
mem_valid  in  1  sdram read data word valid
mem_rid  in  IN  ID of returned read word
valid  out  N  per-master read data strobe, one-hot decode of mem_rid qualified by mem_valid

Behaviour:
- Reset: state=IDLE, grant index=0, rr pointer=0, beat count=0. mem_req=0, mem_wr=0, ack=0, valid=0.
- The mem_addr, mem_data and mem_id outputs are driven from the registered grant index. They are don't-care while mem_req=0.
- IDLE state:
  - If any req is set, select the first set bit searching from pointer p upward, wrapping at N-1 to 0.
  - Register the winner as grant index g.
  - If wr[g]=1, go to WBURST with count=0; otherwise go to READ.
  - Grant decision costs 1 cycle: mem_req rises the cycle after req is seen in IDLE.
  - If no req is set, stay in IDLE.
- READ state:
  - mem_req=req[g], mem_wr=0; mem_addr, mem_data and mem_id are muxed from g combinationally.
  - ack[g]=mem_ack, same cycle.
  - On mem_ack: p<=(g+1) mod N, go to IDLE.
- WBURST state:
  - mem_req=req[g], mem_wr=1, ack[g]=mem_ack.
  - Each mem_ack increments count.
  - On the mem_ack with count==BURST-1: p<=(g+1) mod N, go to IDLE.
  - If a master drops req mid-burst, mem_req drops and the grant is held (no timeout). The master must complete the burst.
- Back-to-back: IDLE always inserts one dead cycle between grants, so the maximum throughput is 1 grant per (words+1) cycles.
- Simultaneous requests: the rotating pointer guarantees that each requesting master is granted within N grants.
- A new req arriving during another master's grant waits; it is not preempted.
- Response path is independent of the grant state and purely combinational: valid[i]=mem_valid && mem_rid==i. Read returns may overlap a new grant.
- Reset mid-burst: reset returns immediately to IDLE with all outputs at reset values. The partial burst is abandoned; the sdram block is reset from the same source.
- Illegal ID: mem_rid>=N produces no valid strobe.

Decomposition:
- Shared package mem_pkg holds AN/DN/BURST defaults and the arbiter state enum (IDLE, READ, WBURST).
- One sub-module, rr_pick: a combinational N-bit rotating priority encoder. Inputs: req vector and pointer. Outputs: index and any-flag.

Test Plan:
- Single master 2 read, addr 24'h000100, mem_ack after 2 cycles -> mem_req rises 1 cycle after req, mem_id=2, mem_addr=24'h000100, ack[2] pulses once, p=3.
- Master 1 write burst, data 1..8, mem_ack every cycle -> 8 ack[1] pulses, mem_data sequence 1..8, mem_wr=1 throughout, then IDLE.
- All 4 masters hold read req continuously starting at p=0 -> grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- Master 3 starts a write burst, master 0 requests after beat 3 -> master 0 is not granted until ack[3] has pulsed 8 times.
- mem_valid with mem_rid=1 during master 2's grant -> valid=4'b0010 in the same cycle, grant to master 2 unaffected.
- Reset asserted after beat 4 of a write -> next cycle mem_req=0, ack=0, state IDLE, p=0; after reset releases, a pending req[1] is granted first.
